cadu_framer: RTL and testbench
==============================

// Module: cadu_framer
// PURPOSE
//   Consumes the hard-bit stream that feeds uw_cadu plus its sync result (bit_offset, weight), aligns to the
//   1024-byte CADU grid, strips the 32-bit ASM 0x1ACFFC1D and emits 1020 payload bytes per frame MSB-first.
//   Tracks lock by checking every ASM; sits between uw_cadu and the Reed-Solomon / VCDU demux stage.
// PARAMETERS
//   BITS_PER_FRAME  1024*8  CADU length in bits, ASM included
//   ASM_BITS        32      sync word length
//   LOCK_THRESH     230     min uw_cadu weight (of 257) accepted to acquire lock
//   ASM_TOL         3       max ASM bit errors counted as a hit
//   MAX_MISSES      4       consecutive ASM misses that drop lock
// PORTS
//   clk           in   1   system clock
//   rst_in        in   1   asynchronous, active-low reset
//   start_in      in   1   pulse: new bit stream begins; clears position counter and lock
//   hard_inp      in   1   hard decision bit (same stream as uw_cadu input)
//   valid_in      in   1   hard_inp qualifier
//   sync_valid    in   1   uw_cadu valid_out pulse
//   sync_offset   in   13  uw_cadu bit_offset ($clog2(BITS_PER_FRAME))
//   sync_weight   in   9   uw_cadu max_offset_weight ($clog2(257))
//   byte_out      out  8   payload byte
//   byte_valid    out  1   byte_out qualifier, one cycle
//   frame_first   out  1   with byte_valid: first payload byte of frame
//   frame_last    out  1   with byte_valid: byte 1019 of frame
//   locked        out  1   framer locked to CADU grid
//   asm_errs      out  6   bit errors in most recent ASM check (0..32), valid with frame_first
// BEHAVIOUR
//   - Reset (rst_in=0, async assert, sync deassert): all outputs 0, state SEARCH, pos=0, miss_ctr=0.
//   - pos: counts accepted bits (valid_in=1) modulo BITS_PER_FRAME from start_in; wraps 8191->0.
//   - States: SEARCH -> WAIT -> ASM -> DATA -> ASM ...; any state -> SEARCH on start_in.
//   - SEARCH: on sync_valid with sync_weight>=LOCK_THRESH latch sync_offset as frame_ofs, go WAIT;
//     weight below threshold: ignored, stay SEARCH.
//   - WAIT: on accepted bit with pos==frame_ofs enter ASM, that bit is ASM bit 0.
//   - ASM: 32 accepted bits shifted in; compare with 0x1ACFFC1D, popcount XOR -> asm_errs.
//     errs<=ASM_TOL: hit, miss_ctr=0, locked=1. Else miss_ctr++; miss_ctr reaching MAX_MISSES -> locked=0,
//     SEARCH, current frame discarded (no bytes). Otherwise proceed to DATA (flywheel through misses).
//   - DATA: 8160 bits packed MSB-first; byte_valid exactly 1 cycle after the 8th bit's accept cycle.
//     Byte index 0 asserts frame_first, index 1019 asserts frame_last; then ASM.
//   - Latency: bit accept -> byte_valid = 1 cycle. No backpressure; bytes are never dropped while in DATA.
//   - valid_in low stalls all counters; gaps of any length are tolerated.
//   - sync_valid while in WAIT/ASM/DATA: ignored (lock maintained by ASM checks only).
//   - start_in and valid_in same cycle: start_in wins, that bit is pos 0.
//   - sync_valid and start_in same cycle: start_in wins, sync result dropped.
// CONFIGURATION
//   CADU_DERAND_EN defined: payload XORed with CCSDS PN (1+x^3+x^5+x^7+x^8), reseeded 0xFF at every
//     frame start, first PN byte 0xFF; sequence advances 1 bit per payload bit. Latency unchanged.
//   Undefined: payload passed through unmodified; no PN logic synthesized.
// STRUCTURE
//   Package lrpt_pkg: CADU_SYNC_WORD (32'h1ACFFC1D), CADU_BITS, CADU_PAYLOAD_BYTES (1020),
//     framer_state_t enum {SEARCH, WAIT, ASM, DATA}, PN_SEED (8'hFF).
//   Sub-module ccsds_pn_gen: 8-bit LFSR, inputs clk/rst_in/reseed/advance, output pn_bit.
// TESTING
//   1 Stream of 8 clean CADUs offset 100 bits, sync_valid offset=100 weight=257 -> locked after 1st ASM,
//     frame_first on byte 0, 1020 bytes/frame matching payload, asm_errs=0.
//   2 sync_weight=200 -> stays SEARCH, no byte_valid, locked=0.
//   3 Locked; corrupt 3 ASM bits -> hit, asm_errs=3; corrupt 4 bits in 4 consecutive ASMs ->
//     3 frames still output, locked=0 and SEARCH at 4th.
//   4 Random valid_in gaps (50% duty) -> identical byte sequence to scenario 1.
//   5 rst_in pulled low mid-DATA -> outputs 0 immediately; after release no bytes until new sync_valid.
//   6 CADU_DERAND_EN, all-zero payload -> bytes 0..3 = 0xFF,0x48,0x0E,0xC0; repeats per frame.

Source files
------------

// File: rtl/lrpt_pkg.sv
// lrpt_pkg: CADU framing constants, framer states and the ASM bit-error counter.
package lrpt_pkg;
   localparam int                CADU_BITS          = 1024 * 8;
   localparam int                ASM_BITS           = 32;
   localparam int                CADU_PAYLOAD_BYTES = 1020;
   localparam int                MAX_MISSES         = 4;
   localparam int                POS_W              = $clog2(CADU_BITS);
   localparam logic [31:0]       CADU_SYNC_WORD     = 32'h1ACFFC1D;
   localparam logic [7:0]        PN_SEED            = 8'hFF;
   localparam logic [8:0]        LOCK_THRESH        = 9'd230;
   localparam logic [5:0]        ASM_TOL            = 6'd3;
   localparam logic [POS_W-1:0]  ASM_LAST           = POS_W'(ASM_BITS - 1);
   localparam logic [POS_W-1:0]  DATA_LAST          = POS_W'(CADU_PAYLOAD_BYTES * 8 - 1);
   localparam logic [2:0]        MISS_LAST          = 3'(MAX_MISSES - 1);

   typedef enum logic [1:0] {SEARCH, WAIT, ASM, DATA} framer_state_t;

   function automatic logic [5:0] bit_errs(input logic [31:0] w);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) n = n + {5'd0, w[i]};
      return n;
   endfunction
endpackage

// File: rtl/ccsds_pn_gen.sv
// ccsds_pn_gen: CCSDS pseudo-noise generator 1+x^3+x^5+x^7+x^8, one bit per advance.
module ccsds_pn_gen
   import lrpt_pkg::*;
(
   input  logic clk,
   input  logic rst_in,
   input  logic reseed,
   input  logic advance,
   output logic pn_bit
);
   logic [7:0] r_lfsr;

   // r_lfsr[7] is the current sequence bit, r_lfsr[0] the newest
   always_ff @(posedge clk or negedge rst_in)
      if (!rst_in)      r_lfsr <= PN_SEED;
      else if (reseed)  r_lfsr <= PN_SEED;
      else if (advance) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[4] ^ r_lfsr[2] ^ r_lfsr[0]};

   assign pn_bit = r_lfsr[7];
endmodule

// File: rtl/cadu_framer.sv
// cadu_framer: aligns hard bits to the CADU grid, checks/strips the ASM, emits payload bytes.
// Define CADU_DERAND_EN to XOR the payload with the CCSDS PN sequence.
module cadu_framer
   import lrpt_pkg::*;
(
   input  logic             clk,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic             hard_inp,
   input  logic             valid_in,
   input  logic             sync_valid,
   input  logic [POS_W-1:0] sync_offset,
   input  logic [8:0]       sync_weight,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   output logic             frame_first,
   output logic             frame_last,
   output logic             locked,
   output logic [5:0]       asm_errs
);
   framer_state_t    r_state, w_next;
   logic [POS_W-1:0] r_pos, r_ofs, r_cnt;
   logic [30:0]      r_sh;
   logic [2:0]       r_miss;
   logic [7:0]       r_byte;
   logic [5:0]       r_errs, w_errs;
   logic             r_rst_meta, r_rst_n, r_bv, r_first, r_last, r_locked;
   logic             w_acc, w_pn, w_bit, w_sync_ok, w_asm_end, w_hit, w_drop, w_byte_end, w_frame_end;

   // reset asserts asynchronously but releases on a clock edge
   always_ff @(posedge clk or negedge rst_in)
      if (!rst_in) {r_rst_n, r_rst_meta} <= 2'b00;
      else         {r_rst_n, r_rst_meta} <= {r_rst_meta, 1'b1};

   assign w_acc       = valid_in && !start_in;
   assign w_bit       = (r_state == DATA) ? hard_inp ^ w_pn : hard_inp;
   assign w_sync_ok   = !start_in && r_state == SEARCH && sync_valid && sync_weight >= LOCK_THRESH;
   assign w_errs      = bit_errs({r_sh, hard_inp} ^ CADU_SYNC_WORD);
   assign w_hit       = w_errs <= ASM_TOL;
   assign w_asm_end   = w_acc && r_state == ASM && r_cnt == ASM_LAST;
   assign w_drop      = w_asm_end && !w_hit && r_miss == MISS_LAST;
   assign w_byte_end  = w_acc && r_state == DATA && r_cnt[2:0] == 3'd7;
   assign w_frame_end = w_byte_end && r_cnt == DATA_LAST;

`ifdef CADU_DERAND_EN
   ccsds_pn_gen u_pn (
      .clk    (clk),
      .rst_in (r_rst_n),
      .reseed (w_asm_end),
      .advance(w_acc && r_state == DATA),
      .pn_bit (w_pn)
   );
`else
   assign w_pn = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         SEARCH:  if (w_sync_ok) w_next = WAIT;
         WAIT:    if (w_acc && r_pos == r_ofs) w_next = ASM;
         ASM:     if (w_asm_end) w_next = w_drop ? SEARCH : DATA;
         DATA:    if (w_frame_end) w_next = ASM;
         default: w_next = SEARCH;
      endcase
      if (start_in) w_next = SEARCH;
   end

   always_ff @(posedge clk or negedge r_rst_n)
      if (!r_rst_n) r_state <= SEARCH;
      else          r_state <= w_next;

   always_ff @(posedge clk or negedge r_rst_n)
      if (!r_rst_n) begin
         r_pos    <= '0;
         r_ofs    <= '0;
         r_cnt    <= '0;
         r_sh     <= '0;
         r_miss   <= '0;
         r_byte   <= '0;
         r_errs   <= '0;
         r_bv     <= 1'b0;
         r_first  <= 1'b0;
         r_last   <= 1'b0;
         r_locked <= 1'b0;
      end else begin
         r_bv    <= w_byte_end;
         r_first <= w_byte_end && r_cnt == POS_W'(7);
         r_last  <= w_frame_end;
         if (w_byte_end) r_byte <= {r_sh[6:0], w_bit};
         if (w_sync_ok) r_ofs <= sync_offset;
         if (start_in) begin
            r_pos    <= {{(POS_W-1){1'b0}}, valid_in};
            r_miss   <= '0;
            r_locked <= 1'b0;
         end else if (valid_in) begin
            r_pos <= r_pos + POS_W'(1);
            r_sh  <= {r_sh[29:0], w_bit};
            // the WAIT->ASM bit is already ASM bit 0
            r_cnt <= (w_next != r_state) ? ((r_state == WAIT) ? POS_W'(1) : '0) : r_cnt + POS_W'(1);
            if (w_asm_end) begin
               r_errs   <= w_errs;
               r_miss   <= (w_hit || w_drop) ? 3'd0 : r_miss + 3'd1;
               r_locked <= w_hit || (r_locked && !w_drop);
            end
         end
      end

   assign byte_out    = r_byte;
   assign byte_valid  = r_bv;
   assign frame_first = r_first;
   assign frame_last  = r_last;
   assign locked      = r_locked;
   assign asm_errs    = r_errs;
endmodule

// File: tb/tb_cadu_framer.sv
// tb_cadu_framer: directed bench for cadu_framer with a frame-level expected-byte model.
`timescale 1ns/1ps
module tb_cadu_framer;
   import lrpt_pkg::*;

   localparam int OFS   = 100;
   localparam int FRAME = 8192;
   localparam int NPAY  = 1020;
`ifdef CADU_DERAND_EN
   localparam int PAY_ON = 0;
`else
   localparam int PAY_ON = 1;
`endif

   typedef struct packed {
      logic [7:0] b;
      logic       f;
      logic       l;
      logic [5:0] e;
      logic       lk;
   } exp_t;

   logic        clk = 1'b0, rst_in = 1'b0, start_in = 1'b0, hard_inp = 1'b0, valid_in = 1'b0, sync_valid = 1'b0;
   logic [12:0] sync_offset = '0;
   logic [8:0]  sync_weight = '0;
   logic [7:0]  byte_out;
   logic        byte_valid, frame_first, frame_last, locked;
   logic [5:0]  asm_errs;

   int          n_run = 0, n_fail = 0, n_bytes = 0, n_frames = 0, bidx = 0, b0 = 0;
   int          ferr[8];
   exp_t        exp_q[$];
   logic [7:0]  first4[8][4];
   logic [5:0]  frm_errs[8];
   logic [7:0]  lit0[4], lit1[4];
`ifdef CADU_DERAND_EN
   logic        pn[NPAY*8];
`endif

   cadu_framer dut (
      .clk        (clk),
      .rst_in     (rst_in),
      .start_in   (start_in),
      .hard_inp   (hard_inp),
      .valid_in   (valid_in),
      .sync_valid (sync_valid),
      .sync_offset(sync_offset),
      .sync_weight(sync_weight),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .frame_first(frame_first),
      .frame_last (frame_last),
      .locked     (locked),
      .asm_errs   (asm_errs)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pay(input int f, input int i);
      return 8'(((i * 7 + f * 61 + 3) & 255) * PAY_ON);
   endfunction

   function automatic logic [7:0] exp_byte(input int f, input int i);
      logic [7:0] p;
      p = '0;
`ifdef CADU_DERAND_EN
      for (int k = 0; k < 8; k++) p[7-k] = pn[i*8+k];
`endif
      return pay(f, i) ^ p;
   endfunction

   // stream bit n: filler before OFS, then CADUs whose first ferr[k] ASM bits are flipped
   function automatic logic gen_bit(input int n);
      int r, k, j;
      logic [7:0]  p;
      logic [31:0] w;
      if (n < OFS) return 1'(((n * 5) >> 2) & 1);
      r = n - OFS;
      k = r / FRAME;
      j = r % FRAME;
      w = CADU_SYNC_WORD;
      if (j < 32) return w[31-j] ^ (j < ferr[k]);
      p = pay(k, (j - 32) / 8);
      return p[7 - (j - 32) % 8];
   endfunction

   // lock rules at frame level: <=3 errors is a hit, the 4th consecutive miss discards the frame and stops
   task automatic model_stream(input int nfr, input int nbytes);
      int   miss;
      logic lk;
      miss = 0;
      lk   = 1'b0;
      for (int k = 0; k < nfr; k++) begin
         if (ferr[k] <= 3) begin
            miss = 0;
            lk   = 1'b1;
         end else begin
            miss++;
            if (miss == 4) return;
         end
         for (int i = 0; i < nbytes; i++)
            exp_q.push_back('{exp_byte(k, i), i == 0, i == NPAY - 1, 6'(ferr[k]), lk});
      end
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_run++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, got, want);
      end
   endtask

   task automatic compare_loop();
      exp_t e;
      forever begin
         @(negedge clk);
         if (byte_valid) begin
            n_bytes++;
            if (frame_first) begin
               bidx = 0;
               if (n_frames < 8) frm_errs[n_frames] = asm_errs;
               n_frames++;
            end
            if (n_frames >= 1 && n_frames <= 8 && bidx < 4) first4[n_frames-1][bidx] = byte_out;
            bidx++;
            n_run++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_byte: got %02h first=%0b last=%0b, want no byte", byte_out, frame_first, frame_last);
            end else begin
               e = exp_q.pop_front();
               if ({byte_out, frame_first, frame_last} !== {e.b, e.f, e.l}) begin
                  n_fail++;
                  $display("FAIL payload_byte: got %02h first=%0b last=%0b, want %02h first=%0b last=%0b",
                           byte_out, frame_first, frame_last, e.b, e.f, e.l);
               end
               if (e.f) begin
                  n_run++;
                  if ({asm_errs, locked} !== {e.e, e.lk}) begin
                     n_fail++;
                     $display("FAIL frame_header: got asm_errs=%0d locked=%0b, want asm_errs=%0d locked=%0b",
                              asm_errs, locked, e.e, e.lk);
                  end
               end
            end
         end
      end
   endtask

   task automatic cyc(input logic st, input logic v, input logic b, input logic sv,
                      input logic [12:0] so, input logic [8:0] sw);
      start_in    = st;
      valid_in    = v;
      hard_inp    = b;
      sync_valid  = sv;
      sync_offset = so;
      sync_weight = sw;
      @(posedge clk);
      #1;
      start_in   = 1'b0;
      valid_in   = 1'b0;
      sync_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic feed(input int from, input int to, input bit gaps);
      for (int n = from; n < to; n++) begin
         if (gaps) while ($urandom_range(0, 1) == 1) idle(1);
         cyc(1'b0, 1'b1, gen_bit(n), 1'b0, '0, '0);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
      $fatal(1);
   end

   initial begin
      fork
         compare_loop();
      join_none
`ifdef CADU_DERAND_EN
      for (int n = 0; n < NPAY * 8; n++) pn[n] = (n < 8) ? 1'b1 : pn[n-1] ^ pn[n-3] ^ pn[n-5] ^ pn[n-8];
      lit0 = '{8'hFF, 8'h48, 8'h0E, 8'hC0};
      lit1 = '{8'hFF, 8'h48, 8'h0E, 8'hC0};
`else
      lit0 = '{8'h03, 8'h0A, 8'h11, 8'h18};
      lit1 = '{8'h40, 8'h47, 8'h4E, 8'h55};
`endif
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {18'd0, byte_out, byte_valid, frame_first, frame_last, locked, asm_errs}, 32'd0);
      rst_in = 1'b1;
      idle(4);

      // weak sync weight: no lock, no bytes
      ferr = '{default: 0};
      b0 = n_bytes;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      feed(0, 50, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 13'd100, 9'd200);
      feed(50, 400, 0);
      idle(2);
      check("weak_sync_locked", {31'd0, locked}, 32'd0);
      check("weak_sync_bytes", n_bytes - b0, 32'd0);

      // clean lock, 3-error hit, then four 4-error misses
      ferr = '{0, 3, 4, 4, 4, 4, 0, 0};
      model_stream(6, NPAY);
      b0 = n_bytes;
      n_frames = 0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      feed(0, 50, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 13'd100, 9'd257);
      feed(50, OFS + 31, 0);
      check("lock_before_asm_end", {31'd0, locked}, 32'd0);
      feed(OFS + 31, OFS + 32, 0);
      check("lock_after_asm", {31'd0, locked}, 32'd1);
      feed(OFS + 32, OFS + 832, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 13'd500, 9'd257);
      feed(OFS + 832, OFS + 5 * FRAME + 96, 0);
      idle(2);
      check("lock_bytes_total", n_bytes - b0, 32'd5100);
      check("lock_queue_empty", exp_q.size(), 32'd0);
      check("lock_frames", n_frames, 32'd5);
      check("miss_drop_locked", {31'd0, locked}, 32'd0);
      check("miss_drop_errs", {26'd0, asm_errs}, 32'd4);
      check("asm_errs_frame0", {26'd0, frm_errs[0]}, 32'd0);
      check("asm_errs_frame1", {26'd0, frm_errs[1]}, 32'd3);
      check("asm_errs_frame2", {26'd0, frm_errs[2]}, 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("frame0_byte%0d", i), {24'd0, first4[0][i]}, {24'd0, lit0[i]});
         check($sformatf("frame1_byte%0d", i), {24'd0, first4[1][i]}, {24'd0, lit1[i]});
      end

      // 50% valid gaps; start+bit+sync together (start wins, that sync dropped)
      ferr = '{default: 0};
      model_stream(1, NPAY);
      b0 = n_bytes;
      n_frames = 0;
      cyc(1'b1, 1'b1, gen_bit(0), 1'b1, 13'd300, 9'd257);
      feed(1, 50, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 13'd100, 9'd257);
      feed(50, OFS + FRAME, 1);
      idle(2);
      check("gaps_bytes", n_bytes - b0, 32'd1020);
      check("gaps_queue_empty", exp_q.size(), 32'd0);
      check("gaps_first_byte", {24'd0, first4[0][0]}, {24'd0, lit0[0]});
      check("gaps_locked", {31'd0, locked}, 32'd1);

      // reset in the middle of DATA, on the cycle of the 100th byte
      model_stream(1, 99);
      b0 = n_bytes;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      feed(0, 50, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 13'd100, 9'd257);
      feed(50, OFS + 32 + 800, 0);
      check("rst_byte_valid_before", {31'd0, byte_valid}, 32'd1);
      rst_in = 1'b0;
      #1;
      check("rst_outputs_zero", {18'd0, byte_out, byte_valid, frame_first, frame_last, locked, asm_errs}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_in = 1'b1;
      idle(4);
      feed(OFS + 832, OFS + 1432, 0);
      idle(2);
      check("rst_bytes_total", n_bytes - b0, 32'd99);
      check("rst_queue_empty", exp_q.size(), 32'd0);
      check("rst_locked", {31'd0, locked}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
